cost_vector_packer: RTL and testbench
=====================================

// Module: cost_vector_packer
// PURPOSE
//  Write-side front end of the census argmin tree. Accepts one matching cost per cycle for
//  disparities 0..NUM_INP-1 of a pixel and assembles them into the packed
//  cost and address vectors that the tree's first layer consumes.
//  Presents each complete vector as a registered, one-cycle strobe.
//  A framing check pads short lists and drops the excess words of long lists,
//  so the tree always sees exactly NUM_INP words.
// PARAMETERS
//  WIDTH       8   bits per cost word
//  ADDR_WIDTH  6   bits per address word; must satisfy 2**ADDR_WIDTH >= NUM_INP
//  NUM_INP     64  cost words per pixel (disparity range); >= 2
// PORTS
//  clk        in   1                   clock; all state on rising edge
//  rst        in   1                   asynchronous reset, active-high
//  en         in   1                   pipeline enable; 0 = whole block frozen
//  in_valid   in   1                   in_cost/in_last valid this cycle
//  in_ready   out  1                   block accepts a word this cycle
//  in_cost    in   WIDTH               cost for the next disparity index
//  in_last    in   1                   marks final cost of this pixel
//  outp       out  WIDTH*NUM_INP       packed costs; word i at [W*N-W*i-1 -: W]
//  outp_addr  out  ADDR_WIDTH*NUM_INP  packed addresses; word i = i (same slicing)
//  outp_valid out  1                   outp holds a fresh vector this cycle
//  err_short  out  1                   sticky: a pixel ended with fewer than NUM_INP words
//  err_long   out  1                   sticky: a pixel supplied more than NUM_INP words
// BEHAVIOUR
//  Reset (async, rst=1): state=FILL, count=0, outp=0, outp_valid=0,
//   err_short=0, err_long=0, assembly buffer=0.
//   outp_addr is a constant (word i = i) and is independent of reset.
//  Accept = en & in_valid & in_ready. in_ready = en in both states.
//   No internal backpressure: the tree cannot stall.
//  en=0: no state, count, buffer or output register changes.
//   outp_valid holds its value, so the downstream en-gated tree stays in lockstep.
//  Double buffering: an assembly buffer plus a separate outp register.
//   Back-to-back pixels stream with zero bubbles.
//  FILL, on accept with count<NUM_INP-1 and in_last=0:
//   write buffer[count]=in_cost; count++.
//  FILL, on accept with in_last=1 and count<=NUM_INP-1:
//   outp <= buffer with word[count]=in_cost.
//   Words count+1..NUM_INP-1 are padded to all-ones.
//   If count<NUM_INP-1, set err_short. Then count=0.
//  FILL, on accept with count==NUM_INP-1 and in_last=0:
//   emit outp as above; set err_long; count=0; state=DROP.
//  DROP: accepted words are discarded. Accept with in_last=1 returns to FILL.
//  Latency: outp/outp_valid update on the edge that accepts the completing word.
//   outp_valid=1 for exactly one enabled cycle after that edge, then 0
//   unless another vector completes on the next accept.
//  On an enabled cycle with no completion, outp_valid=0 and outp holds its last value.
//  Words are never reordered. Padding is all-ones so it never beats a real
//   cost except on ties; tie resolution belongs to the argmin tree.
//  err_* flags clear only on rst.
//  Reset mid-pixel discards the partial buffer. The next accepted word is disparity 0.
// TESTING
//  (N=4,W=8) costs 9,3,7,5, last on 5 -> next cycle outp=09_03_07_05, outp_addr=0_1_2_3,
//   outp_valid 1 cycle.
//  Two pixels back-to-back, in_valid held high -> outp_valid pulses on cycles 5 and 9,
//   no bubble, in_ready always 1.
//  Costs 4,2 with last on 2 -> outp=04_02_FF_FF, err_short=1, following pixel starts at word 0.
//  Six words 1..6, last on 6 -> outp=01_02_03_04, err_long=1, words 5,6 dropped,
//   next pixel packs normally.
//  en=0 for 3 cycles mid-pixel with in_valid=1 -> in_ready=0, no words lost,
//   outp/outp_valid frozen, result identical to the unstalled run.
//  rst pulsed after 2 words -> all outputs 0 immediately (async).
//   4 new words then give a clean vector with no error flags.

Source files
------------

// File: rtl/cost_vector_packer_if.sv
// Handshake and vector bus between a cost producer and the census argmin tree front end.
// The slave modport is the packer's view; the master modport is the producer's view.
interface cost_vector_packer_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_INP    = 64
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_cost;
  logic                          in_last;
  logic [WIDTH*NUM_INP-1:0]      outp;
  logic [ADDR_WIDTH*NUM_INP-1:0] outp_addr;
  logic                          outp_valid;
  logic                          err_short;
  logic                          err_long;

  modport slave (
    input  in_valid, in_cost, in_last,
    output in_ready, outp, outp_addr, outp_valid, err_short, err_long
  );

  modport master (
    output in_valid, in_cost, in_last,
    input  in_ready, outp, outp_addr, outp_valid, err_short, err_long
  );
endinterface

// File: rtl/cost_vector_packer.sv
// Collects one matching cost per cycle into a NUM_INP-word vector for the argmin tree,
// padding short pixels with all-ones and discarding the excess words of long ones.
module cost_vector_packer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_INP    = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  cost_vector_packer_if.slave bus
);

  localparam int              CW       = $clog2(NUM_INP);
  localparam int              VW       = WIDTH * NUM_INP;
  localparam logic [0:0]      S_FILL   = 1'b0;
  localparam logic [0:0]      S_DROP   = 1'b1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_INP - 1);

  logic [0:0]      state_p0;
  logic [CW-1:0]   count_p0;
  logic [VW-1:0]   buf_p0;
  logic [VW-1:0]   outp_p1;
  logic            vld_p1;
  logic            err_short_p1;
  logic            err_long_p1;

  logic            accept;
  logic            in_fill;
  logic            at_end;
  logic            complete;
  logic            write_word;
  logic            go_long;
  logic            go_short;
  logic [VW-1:0]   vec_next;

  // Word idx of the emitted vector: buffered below the completing slot, padded above it.
  function automatic logic [WIDTH-1:0] pick_word(input int idx,
                                                 input logic [CW-1:0] cnt,
                                                 input logic [WIDTH-1:0] held,
                                                 input logic [WIDTH-1:0] cost);
    if (idx < int'(cnt))
      return held;
    else if (idx == int'(cnt))
      return cost;
    else
      return '1;
  endfunction

  assign accept     = en & bus.in_valid;
  assign in_fill    = (state_p0 == S_FILL);
  assign at_end     = (count_p0 == LAST_IDX);
  assign complete   = accept & in_fill & (bus.in_last | at_end);
  assign write_word = accept & in_fill & ~bus.in_last & ~at_end;
  assign go_long    = accept & in_fill & ~bus.in_last & at_end;
  assign go_short   = accept & in_fill & bus.in_last & ~at_end;

  always_comb begin
    vec_next = '0;
    for (int i = 0; i < NUM_INP; i++)
      vec_next[VW-1-WIDTH*i -: WIDTH] = pick_word(i, count_p0,
                                                  buf_p0[VW-1-WIDTH*i -: WIDTH],
                                                  bus.in_cost);
  end

  // Stage p0: assembly buffer and framing state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= S_FILL;
      count_p0 <= '0;
      buf_p0   <= '0;
    end else if (en) begin
      if (write_word) begin
        for (int i = 0; i < NUM_INP; i++)
          if (CW'(i) == count_p0)
            buf_p0[VW-1-WIDTH*i -: WIDTH] <= bus.in_cost;
        count_p0 <= count_p0 + 1'b1;
      end
      if (complete)
        count_p0 <= '0;
      if (go_long)
        state_p0 <= S_DROP;
      else if (accept && !in_fill && bus.in_last)
        state_p0 <= S_FILL;
    end
  end

  // Stage p1: output vector, strobe and sticky framing errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outp_p1      <= '0;
      vld_p1       <= 1'b0;
      err_short_p1 <= 1'b0;
      err_long_p1  <= 1'b0;
    end else if (en) begin
      vld_p1 <= complete;
      if (complete)
        outp_p1 <= vec_next;
      if (go_short)
        err_short_p1 <= 1'b1;
      if (go_long)
        err_long_p1 <= 1'b1;
    end
  end

  always_comb begin
    bus.outp_addr = '0;
    for (int i = 0; i < NUM_INP; i++)
      bus.outp_addr[ADDR_WIDTH*NUM_INP-1-ADDR_WIDTH*i -: ADDR_WIDTH] = ADDR_WIDTH'(i);
  end

  assign bus.in_ready   = en;
  assign bus.outp       = outp_p1;
  assign bus.outp_valid = vld_p1;
  assign bus.err_short  = err_short_p1;
  assign bus.err_long   = err_long_p1;

endmodule

// File: tb/tb_cost_vector_packer.sv
// Bench for cost_vector_packer at NUM_INP=4, WIDTH=8: queue-based pixel model checked
// every cycle, plus hand-computed vectors for the directed scenarios.
module tb_cost_vector_packer;

  localparam int W  = 8;
  localparam int AW = 2;
  localparam int N  = 4;

  logic clk;
  logic rst;
  logic en;
  logic chk_on;
  int   errors;
  int   checks;

  cost_vector_packer_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_INP(N)) bus ();

  cost_vector_packer #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_INP(N)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: gather words of the current pixel in a queue, emit on last or when full.
  logic [W-1:0]   q[$];
  bit             dropping;
  logic [W*N-1:0] mv;
  logic [W*N-1:0] m_outp     = '0;
  logic           m_valid    = 1'b0;
  logic           m_es       = 1'b0;
  logic           m_el       = 1'b0;
  logic [AW*N-1:0] exp_addr;

  initial begin
    for (int i = 0; i < N; i++) exp_addr[AW*N-1-AW*i -: AW] = AW'(i);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      dropping = 0;
      m_outp  <= '0;
      m_valid <= 1'b0;
      m_es    <= 1'b0;
      m_el    <= 1'b0;
    end else if (en) begin
      m_valid <= 1'b0;
      if (bus.in_valid) begin
        if (dropping) begin
          if (bus.in_last) dropping = 0;
        end else begin
          q.push_back(bus.in_cost);
          if (bus.in_last || q.size() == N) begin
            mv = '1;
            foreach (q[i]) mv[W*N-1-W*i -: W] = q[i];
            m_outp  <= mv;
            m_valid <= 1'b1;
            if (q.size() < N) m_es <= 1'b1;
            if (!bus.in_last) begin
              m_el <= 1'b1;
              dropping = 1;
            end
            q.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("outp_valid", bus.outp_valid, m_valid);
      chk("outp",       bus.outp,       m_outp);
      chk("err_short",  bus.err_short,  m_es);
      chk("err_long",   bus.err_long,   m_el);
      chk("in_ready",   bus.in_ready,   en);
      chk("outp_addr",  bus.outp_addr,  exp_addr);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] c, input logic l, input logic e);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_cost  = c;
    bus.in_last  = l;
    en           = e;
  endtask

  task automatic send(input logic [W-1:0] c, input logic l);
    drive(1'b1, c, l, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    chk_on = 1'b0;
    rst = 1'b0;
    en  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cost  = '0;
    bus.in_last  = 1'b0;
    #2 rst = 1'b1;
    #1 chk_on = 1'b1;
    @(negedge clk);
    chk("rst_outp",  bus.outp, 32'h0);
    chk("rst_valid", bus.outp_valid, 1'b0);
    chk("rst_errs",  {bus.err_short, bus.err_long}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic pixel
    send(8'd9, 0); send(8'd3, 0); send(8'd7, 0); send(8'd5, 1);
    idle();
    @(negedge clk);
    chk("s1_outp",  bus.outp, 32'h09030705);
    chk("s1_model", m_outp, 32'h09030705);
    chk("s1_valid", bus.outp_valid, 1'b1);
    chk("s1_addr",  bus.outp_addr, 8'h1B);
    idle();
    @(negedge clk);
    chk("s1_pulse_end", bus.outp_valid, 1'b0);

    // back-to-back pixels
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 1);
    send(8'd5, 0); send(8'd6, 0); send(8'd7, 0); send(8'd8, 1);
    idle();
    @(negedge clk);
    chk("s2_outp",  bus.outp, 32'h05060708);
    chk("s2_valid", bus.outp_valid, 1'b1);

    // short pixel then normal
    send(8'd4, 0); send(8'd2, 1);
    idle();
    @(negedge clk);
    chk("s3_outp",  bus.outp, 32'h0402FFFF);
    chk("s3_model", m_outp, 32'h0402FFFF);
    chk("s3_short", bus.err_short, 1'b1);
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 1);
    idle();
    @(negedge clk);
    chk("s3_next", bus.outp, 32'h01020304);

    // long pixel then normal
    for (int i = 1; i <= 6; i++) send(W'(i), (i == 6));
    idle();
    @(negedge clk);
    chk("s4_outp",  bus.outp, 32'h01020304);
    chk("s4_long",  bus.err_long, 1'b1);
    chk("s4_valid", bus.outp_valid, 1'b0);
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0); send(8'd40, 1);
    idle();
    @(negedge clk);
    chk("s4_next", bus.outp, 32'h0A141E28);

    // enable stalls: right after a completion and mid-pixel
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'd99, 1'b0, 1'b0);
    @(negedge clk);
    chk("s5_frozen_valid", bus.outp_valid, 1'b1);
    chk("s5_ready",        bus.in_ready, 1'b0);
    send(8'd11, 0); send(8'd22, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'd99, 1'b0, 1'b0);
    send(8'd33, 0); send(8'd44, 1);
    idle();
    @(negedge clk);
    chk("s5_outp", bus.outp, 32'h0B16212C);

    // async reset mid-pixel
    send(8'd1, 0); send(8'd2, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("s6_rst_outp",  bus.outp, 32'h0);
    chk("s6_rst_valid", bus.outp_valid, 1'b0);
    chk("s6_rst_errs",  {bus.err_short, bus.err_long}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'd5, 0); send(8'd6, 0); send(8'd7, 0); send(8'd8, 1);
    idle();
    @(negedge clk);
    chk("s6_outp", bus.outp, 32'h05060708);
    chk("s6_errs", {bus.err_short, bus.err_long}, 2'b00);

    idle(); idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
